// File: rtl/led_ctrl.sv
// led_ctrl
// Memory-mapped LED sequencer. Software programs a base pattern, a mode and a
// tick period. The block then emits timed full-word writes to the LED register
// block, so the CPU does not have to animate the LEDs itself.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high; clears all state
//   we         : bus write strobe (address already decoded by the bridge)
//   addr       : word address, 0=PATTERN 1=CTRL 2=PERIOD 3=STEPS
//   byteen     : bus write byte enables
//   wdata      : bus write data
//   rdata      : combinational read data of the register selected by addr
//   led_byteen : 4'hF for one cycle after every load of cur, else 4'h0
//   led_wdata  : displayed pattern (cur), wired to the LED register LED_in
module led_ctrl #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        byteen,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [3:0]        led_byteen,
  output logic [31:0]       led_wdata
);

  localparam logic [ADDR_W-1:0] A_PATTERN = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PERIOD  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STEPS   = ADDR_W'(3);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_ROTL   = 2'b10;

  logic [31:0] pattern_reg, pattern_next;
  logic [2:0]  ctrl_reg, ctrl_next;
  logic [31:0] period_reg, period_next;
  logic [31:0] steps_reg, steps_next;
  logic [31:0] cur_reg, cur_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        upd_reg, upd_next;

  // Byte-lane merges of the bus data into the current register contents.
  logic [31:0] pattern_wr, period_wr;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign pattern_wr[8*gi +: 8] = byteen[gi] ? wdata[8*gi +: 8] : pattern_reg[8*gi +: 8];
      assign period_wr[8*gi +: 8]  = byteen[gi] ? wdata[8*gi +: 8] : period_reg[8*gi +: 8];
    end
  endgenerate

  logic hit_pattern, hit_ctrl, hit_period, cfg_write;
  logic running, tick;

  always_comb begin
    hit_pattern = we && (addr == A_PATTERN) && (byteen != 4'h0);
    hit_ctrl    = we && (addr == A_CTRL)    && (byteen != 4'h0);
    hit_period  = we && (addr == A_PERIOD)  && (byteen != 4'h0);
    // A CTRL write with only upper lanes enabled still restarts the sequence,
    // even though CTRL itself keeps its value.
    cfg_write   = hit_pattern || hit_ctrl || hit_period;
    running     = ctrl_reg[0] && (ctrl_reg[2:1] != MODE_STATIC);
    // A config write in the same cycle wins over the tick.
    tick        = running && (cnt_reg == period_reg) && !cfg_write;
  end

  always_comb begin
    pattern_next = hit_pattern ? pattern_wr : pattern_reg;
    period_next  = hit_period  ? period_wr  : period_reg;
    ctrl_next    = (hit_ctrl && byteen[0]) ? wdata[2:0] : ctrl_reg;
  end

  always_comb begin
    cur_next   = cur_reg;
    cnt_next   = cnt_reg;
    steps_next = steps_reg;
    upd_next   = 1'b0;
    if (cfg_write) begin
      cnt_next = '0;
      cur_next = pattern_next;
      upd_next = 1'b1;
    end else if (!running) begin
      cnt_next = '0;
      cur_next = pattern_reg;
    end else if (tick) begin
      cnt_next   = '0;
      steps_next = steps_reg + 32'd1;
      upd_next   = 1'b1;
      case (ctrl_reg[2:1])
        MODE_BLINK: cur_next = (cur_reg == 32'h0) ? pattern_reg : 32'h0;
        MODE_ROTL:  cur_next = {cur_reg[30:0], cur_reg[31]};
        default:    cur_next = {cur_reg[0], cur_reg[31:1]};
      endcase
    end else begin
      cnt_next = cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_reg <= '0;
      ctrl_reg    <= '0;
      period_reg  <= '0;
      steps_reg   <= '0;
      cur_reg     <= '0;
      cnt_reg     <= '0;
      upd_reg     <= 1'b0;
    end else begin
      pattern_reg <= pattern_next;
      ctrl_reg    <= ctrl_next;
      period_reg  <= period_next;
      steps_reg   <= steps_next;
      cur_reg     <= cur_next;
      cnt_reg     <= cnt_next;
      upd_reg     <= upd_next;
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (addr)
      A_PATTERN: rdata = pattern_reg;
      A_CTRL:    rdata = {29'h0, ctrl_reg};
      A_PERIOD:  rdata = period_reg;
      A_STEPS:   rdata = steps_reg;
      default:   rdata = 32'h0;
    endcase
  end

  assign led_byteen = upd_reg ? 4'hF : 4'h0;
  assign led_wdata  = cur_reg;

endmodule

// File: tb/tb_led_ctrl.sv
// Testbench for led_ctrl. Stimulus pushes the expected LED write (edge number
// and data) into a queue; a monitor on the falling edge pops and compares
// whenever a pulse is due, and checks idle cycles for stray pulses.
module tb_led_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [3:0]  byteen = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [3:0]  led_byteen;
  logic [31:0] led_wdata;

  led_ctrl #(.ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .byteen(byteen),
    .wdata(wdata), .rdata(rdata), .led_byteen(led_byteen), .led_wdata(led_wdata)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct {
    int          e;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic push(input int e, input logic [31:0] d);
    exp_t x;
    x.e = e;
    x.d = d;
    q.push_back(x);
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].e < edge_no) begin
        chk("missed_pulse_edge", 32'(edge_no), 32'(q[0].e));
        q.pop_front();
      end
      if (q.size() > 0 && q[0].e == edge_no) begin
        chk("pulse_byteen", {28'h0, led_byteen}, 32'hF);
        chk("pulse_wdata", led_wdata, q[0].d);
        last = q[0].d;
        q.pop_front();
      end else begin
        chk("idle_byteen", {28'h0, led_byteen}, 32'h0);
        chk("idle_wdata", led_wdata, last);
      end
    end
  end

  // Called mid-cycle; the write lands on the next rising edge, returned in e.
  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d, output int e);
    addr   = a;
    byteen = be;
    wdata  = d;
    we     = 1'b1;
    e      = edge_no + 1;
    @(posedge clk);
    #1;
    we     = 1'b0;
    byteen = 4'h0;
    $display("write addr=%0d byteen=%h data=%h at edge %0d", a, be, d, e);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    chk(name, rdata, exp);
    $display("read  addr=%0d data=%h", a, rdata);
  endtask

  task automatic wait_edge(input int n);
    while (edge_no < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_byteen", {28'h0, led_byteen}, 32'h0);
    chk("reset_wdata", led_wdata, 32'h0);
    reset = 1'b0;
    wait_edge(edge_no + 20);
    rd(2'd0, 32'h0, "reset_pattern");
    rd(2'd1, 32'h0, "reset_ctrl");
    rd(2'd2, 32'h0, "reset_period");
    rd(2'd3, 32'h0, "reset_steps");

    // Byte-masked PATTERN write.
    wait_edge(edge_no + 1);
    wr(2'd0, 4'b0101, 32'h12345678, e); push(e, 32'h00340078);
    rd(2'd0, 32'h00340078, "pattern_masked");

    // Rotate left, PERIOD=3.
    wr(2'd0, 4'hF, 32'h0000000F, e); push(e, 32'h0F);
    wr(2'd2, 4'hF, 32'd3, e);        push(e, 32'h0F);
    wr(2'd1, 4'h1, 32'h5, e);
    push(e, 32'h0F); push(e + 4, 32'h1E); push(e + 8, 32'h3C); push(e + 12, 32'h78);
    wait_edge(e + 12);
    rd(2'd3, 32'd3, "rotl_steps");
    wr(2'd1, 4'h1, 32'h0, e); push(e, 32'h0F);

    // Writes that are not config writes.
    wr(2'd3, 4'hF, 32'hDEADBEEF, e);
    rd(2'd3, 32'd3, "steps_readonly");
    wr(2'd0, 4'h0, 32'hFFFFFFFF, e);
    rd(2'd0, 32'h0F, "pattern_zero_byteen");

    // CTRL masking: upper bits ignored, upper lanes restart but leave CTRL alone.
    wr(2'd1, 4'hF, 32'hFFFFFFF9, e); push(e, 32'h0F);
    rd(2'd1, 32'h1, "ctrl_upper_bits");
    wr(2'd1, 4'b1110, 32'h7, e);     push(e, 32'h0F);
    rd(2'd1, 32'h1, "ctrl_lane0_only");

    // Blink, PERIOD=0: a pulse every cycle.
    wr(2'd0, 4'hF, 32'hFF, e); push(e, 32'hFF);
    wr(2'd2, 4'hF, 32'd0, e);  push(e, 32'hFF);
    wr(2'd1, 4'h1, 32'h3, e);  push(e, 32'hFF);
    for (int k = 1; k <= 6; k++) push(e + k, (k % 2 == 1) ? 32'h0 : 32'hFF);
    wait_edge(e + 6);
    wr(2'd1, 4'h1, 32'h0, e);  push(e, 32'hFF);
    rd(2'd3, 32'd9, "blink_steps");

    // Rotate right, PERIOD=1, PATTERN write landing on a tick edge.
    wr(2'd2, 4'hF, 32'd1, e);  push(e, 32'hFF);
    wr(2'd0, 4'hF, 32'h3, e);  push(e, 32'h3);
    wr(2'd1, 4'h1, 32'h7, e);  push(e, 32'h3);
    push(e + 2, 32'h80000001); push(e + 4, 32'hC0000000);
    wait_edge(e + 5);
    wr(2'd0, 4'hF, 32'h80000001, e); push(e, 32'h80000001); push(e + 2, 32'hC0000000);
    rd(2'd3, 32'd11, "rotr_steps_write_wins");
    rd(2'd0, 32'h80000001, "rotr_pattern");
    wait_edge(e + 2);
    rd(2'd3, 32'd12, "rotr_steps_after");

    // Blink with PERIOD=1, then reset during a pulse.
    wr(2'd1, 4'h1, 32'h3, e); push(e, 32'h80000001); push(e + 2, 32'h0);
    wait_edge(e + 2);
    chk("pre_reset_byteen", {28'h0, led_byteen}, 32'hF);
    #1;
    reset = 1'b1;
    q.delete();
    last = 32'h0;
    #1;
    chk("async_reset_byteen", {28'h0, led_byteen}, 32'h0);
    chk("async_reset_wdata", led_wdata, 32'h0);
    chk("async_reset_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_edge(edge_no + 10);
    rd(2'd1, 32'h0, "post_reset_ctrl");
    rd(2'd0, 32'h0, "post_reset_pattern");
    rd(2'd3, 32'h0, "post_reset_steps");
    wait_edge(edge_no + 3);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
